// File: rtl/acc_requant_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : acc_requant_pkg
//  Purpose  : Shared numeric-format constants for the accelerator datapath.
//             Holds the default operand width, the accumulator width and
//             the default Q-format fractional bit count.
//  Revision : 1.0  initial release
// ============================================================================
package acc_requant_pkg;

    localparam int BITWIDTH_DEFAULT  = 8;
    localparam int ACC_WIDTH         = 2 * BITWIDTH_DEFAULT;
    localparam int FRAC_BITS_DEFAULT = 4;

    // Width of acc + bias with one guard bit so the sum can never overflow.
    function automatic int sum_width(input int bitwidth);
        return 2 * bitwidth + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/acc_requant_sat_round.sv
`default_nettype none
// ============================================================================
//  Module   : sat_round
//  Purpose  : Combinational round / ReLU / saturate of a biased accumulator.
//  Ports    : sum  - signed (2*BITWIDTH+1)-bit biased accumulator
//             q    - signed BITWIDTH-bit requantized activation
//             sat  - result was clipped to the representable range
//  Revision : 1.0  initial release
// ============================================================================
module sat_round
    import acc_requant_pkg::*;
#(
    parameter int BITWIDTH  = BITWIDTH_DEFAULT,
    parameter int FRAC_BITS = FRAC_BITS_DEFAULT,
    parameter int RELU_EN   = 1
) (
    input  logic signed [2*BITWIDTH:0]  sum,
    output logic        [BITWIDTH-1:0]  q,
    output logic                        sat
);

    localparam int SW = sum_width(BITWIDTH);
    // One extra bit so adding the rounding constant cannot overflow.
    localparam int EW = SW + 1;

    localparam logic        [EW-1:0] ONE   = {{(EW-1){1'b0}}, 1'b1};
    // 2^(FRAC_BITS-1), or zero when FRAC_BITS == 0.
    localparam logic        [EW-1:0] ROUND = (ONE << FRAC_BITS) >> 1;
    localparam logic signed [EW-1:0] MAXV  = {{(EW-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] MINV  = {{(EW-BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}};

    logic signed [EW-1:0] w_ext;
    logic signed [EW-1:0] w_r;

    always_comb begin
        w_ext = {sum[SW-1], sum} + ROUND;
        w_r   = w_ext >>> FRAC_BITS;
        q     = w_r[BITWIDTH-1:0];
        sat   = 1'b0;
        if ((RELU_EN != 0) && w_r[EW-1]) begin
            // ReLU clamp is a normal result, not a saturation event.
            q = '0;
        end else if (w_r > MAXV) begin
            q   = MAXV[BITWIDTH-1:0];
            sat = 1'b1;
        end else if (w_r < MINV) begin
            q   = MINV[BITWIDTH-1:0];
            sat = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/acc_requant.sv
`default_nettype none
// ============================================================================
//  Module   : acc_requant
//  Purpose  : Two-stage valid/ready pipeline: add bias, then round, ReLU and
//             saturate the accumulator down to a BITWIDTH activation.
//  Ports    : clk, reset                 - clock, synchronous active-high reset
//             in_valid/in_ready          - input handshake
//             in_acc, in_bias            - signed 2*BITWIDTH operands
//             out_valid/out_ready, out_q - output handshake and activation
//             sat_count                  - saturated results delivered (sticky max)
//             busy                       - any stage holds data
//  Revision : 1.0  initial release
// ============================================================================
module acc_requant
    import acc_requant_pkg::*;
#(
    parameter int BITWIDTH  = BITWIDTH_DEFAULT,
    parameter int FRAC_BITS = FRAC_BITS_DEFAULT,
    parameter int RELU_EN   = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [2*BITWIDTH-1:0] in_acc,
    input  logic signed [2*BITWIDTH-1:0] in_bias,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic        [BITWIDTH-1:0]   out_q,
    output logic        [15:0]           sat_count,
    output logic                         busy
);

    localparam int SW = sum_width(BITWIDTH);

    logic                 r_s1_valid;
    logic signed [SW-1:0] r_s1_sum;
    logic                 r_s2_valid;
    logic [BITWIDTH-1:0]  r_s2_q;
    logic                 r_s2_sat;
    logic [15:0]          r_sat_count;

    logic                 w_s2_adv;
    logic                 w_s1_adv;
    logic                 w_out_fire;
    logic signed [SW-1:0] w_sum;
    logic [BITWIDTH-1:0]  w_q;
    logic                 w_sat;

    // Stage-to-stage advance depends only on downstream state and out_ready,
    // so in_ready never sees in_valid.
    assign w_out_fire = r_s2_valid & out_ready;
    assign w_s2_adv   = ~r_s2_valid | out_ready;
    assign w_s1_adv   = ~r_s1_valid | w_s2_adv;
    assign w_sum      = {in_acc[2*BITWIDTH-1], in_acc} + {in_bias[2*BITWIDTH-1], in_bias};

    sat_round #(
        .BITWIDTH  (BITWIDTH),
        .FRAC_BITS (FRAC_BITS),
        .RELU_EN   (RELU_EN)
    ) u_sat_round (
        .sum (r_s1_sum),
        .q   (w_q),
        .sat (w_sat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_sum    <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_q      <= '0;
            r_s2_sat    <= 1'b0;
            r_sat_count <= '0;
        end else begin
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_q   <= w_q;
                    r_s2_sat <= w_sat;
                end
            end
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_sum <= w_sum;
                end
            end
            if (w_out_fire && r_s2_sat && (r_sat_count != 16'hFFFF)) begin
                r_sat_count <= r_sat_count + 16'd1;
            end
        end
    end

    assign in_ready  = w_s1_adv;
    assign out_valid = r_s2_valid;
    assign out_q     = r_s2_q;
    assign sat_count = r_sat_count;
    assign busy      = r_s1_valid | r_s2_valid;

endmodule
`default_nettype wire

// File: tb/tb_acc_requant.sv
`default_nettype none
// ============================================================================
//  Module   : tb_acc_requant
//  Purpose  : Directed self-checking bench for acc_requant, BITWIDTH=8,
//             FRAC_BITS=4; one instance with ReLU, one without.
//  Revision : 1.0  initial release
// ============================================================================
module tb_acc_requant;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_acc;
    logic [15:0] in_bias;
    logic        out_ready;

    logic        in_ready_r,  in_ready_l;
    logic        out_valid_r, out_valid_l;
    logic [7:0]  out_q_r,     out_q_l;
    logic [15:0] sat_count_r, sat_count_l;
    logic        busy_r,      busy_l;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_sat_r = 0;
    int exp_sat_l = 0;

    acc_requant #(.BITWIDTH(8), .FRAC_BITS(4), .RELU_EN(1)) u_dut_relu (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_r),
        .in_acc(in_acc), .in_bias(in_bias), .out_valid(out_valid_r),
        .out_ready(out_ready), .out_q(out_q_r), .sat_count(sat_count_r),
        .busy(busy_r)
    );

    acc_requant #(.BITWIDTH(8), .FRAC_BITS(4), .RELU_EN(0)) u_dut_lin (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_l),
        .in_acc(in_acc), .in_bias(in_bias), .out_valid(out_valid_l),
        .out_ready(out_ready), .out_q(out_q_l), .sat_count(sat_count_l),
        .busy(busy_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Send one item with out_ready high; it must appear two edges after it is
    // presented and be consumed on the following edge.
    task automatic run_one(input logic [15:0] a, input logic [15:0] b,
                           input logic [7:0] e_relu, input logic [7:0] e_lin,
                           input int s_relu, input int s_lin);
        @(negedge clk);
        in_valid  = 1'b1;
        in_acc    = a;
        in_bias   = b;
        out_ready = 1'b1;
        #1;
        check("in_ready", in_ready_r, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("lat1_no_valid", out_valid_r, 0);
        @(negedge clk);
        check("out_valid_relu", out_valid_r, 1);
        check("out_valid_lin", out_valid_l, 1);
        check("q_relu", out_q_r, e_relu);
        check("q_lin", out_q_l, e_lin);
        exp_sat_r += s_relu;
        exp_sat_l += s_lin;
        @(negedge clk);
        check("sat_relu", sat_count_r, exp_sat_r);
        check("sat_lin", sat_count_l, exp_sat_l);
        check("drained", out_valid_r, 0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_acc    = '0;
        in_bias   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid_r, 0);
        check("rst_out_q", out_q_r, 0);
        check("rst_sat", sat_count_r, 0);
        check("rst_busy", busy_r, 0);
        reset = 1'b0;
        #1;
        check("rst_in_ready", in_ready_r, 1);

        //      acc       bias      relu   lin    sat_r sat_l
        run_one(16'd24,   16'd0,    8'd2,  8'd2,  0, 0);
        run_one(-16'sd24, 16'd0,    8'd0,  8'hFF, 0, 0);
        run_one(16'h8000, 16'hFFFF, 8'd0,  8'h80, 0, 1);
        run_one(16'h7FFF, 16'h7FFF, 8'd127,8'd127,1, 1);
        run_one(-16'sd100,16'd0,    8'd0,  8'hFA, 0, 0);
        run_one(16'd2039, 16'd0,    8'd127,8'd127,0, 0);
        run_one(16'd2040, 16'd0,    8'd127,8'd127,1, 1);
        run_one(16'd8,    16'd0,    8'd1,  8'd1,  0, 0);
        run_one(-16'sd8,  16'd0,    8'd0,  8'd0,  0, 0);
        run_one(-16'sd9,  16'd0,    8'd0,  8'hFF, 0, 0);
        run_one(-16'sd2056,16'd0,   8'd0,  8'h80, 0, 0);
        run_one(-16'sd2057,16'd0,   8'd0,  8'h80, 0, 1);
        run_one(16'd100,  -16'sd60, 8'd3,  8'd3,  0, 0);

        // Streaming with out_ready pattern 1,0,0,1.
        begin
            logic [3:0] pat;
            int sent = 0;
            int recv = 0;
            int occ  = 0;
            int cyc  = 0;
            logic stall_prev = 1'b0;
            logic [7:0] held_q = '0;
            logic in_fire, out_fire;
            pat = 4'b1001;
            while (recv < 8 && cyc < 60) begin
                @(negedge clk);
                out_ready = pat[3 - (cyc % 4)];
                in_valid  = (sent < 8);
                in_acc    = 16'(16 * sent);
                in_bias   = '0;
                #1;
                if (stall_prev) begin
                    check("stall_valid", out_valid_r, 1);
                    check("stall_q", out_q_r, held_q);
                end
                check("stream_in_ready", in_ready_r, !(occ == 2 && !out_ready));
                check("stream_busy", busy_r, occ != 0);
                in_fire  = in_valid && in_ready_r;
                out_fire = out_valid_r && out_ready;
                if (out_fire) begin
                    check("stream_q", out_q_r, recv);
                    recv++;
                end
                stall_prev = out_valid_r && !out_ready;
                held_q     = out_q_r;
                if (in_fire) sent++;
                occ = occ + (in_fire ? 1 : 0) - (out_fire ? 1 : 0);
                cyc++;
            end
            check("stream_count", recv, 8);
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end

        // Reset with two items in flight.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_acc    = 16'd320;
        @(negedge clk);
        in_acc    = 16'h7FFF;
        in_bias   = 16'h7FFF;
        @(negedge clk);
        in_valid  = 1'b0;
        check("inflight_busy", busy_r, 1);
        check("inflight_valid", out_valid_r, 1);
        reset     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", out_valid_r, 0);
        check("mid_rst_busy", busy_r, 0);
        check("mid_rst_sat", sat_count_l, 0);
        reset    = 1'b0;
        in_valid = 1'b0;
        in_bias  = '0;
        exp_sat_r = 0;
        exp_sat_l = 0;
        repeat (3) begin
            @(negedge clk);
            check("no_stale_valid", out_valid_r, 0);
        end
        run_one(16'd48, 16'd0, 8'd3, 8'd3, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
